// File: rtl/spike_column_arbiter.sv
// spike_column_arbiter
// Collects per-column spike events into small per-column FIFOs and issues them
// one per cycle to the spike router, with round-robin fairness between columns.
// Events arriving at a full FIFO that is not being popped are dropped. Dropped
// events are counted in a saturating counter and flagged by a sticky overflow bit.
//
// Build option: define SPIKE_ARB_STRICT_PRIO_EN to remove the round-robin
// pointer. Arbitration then always picks the lowest-index non-empty column.
//
// Handshake: out_valid/out_col/out_on_off describe one spike. A transfer happens
// on a rising edge where out_valid=1 and out_ready=1. Once out_valid is raised,
// out_col and out_on_off hold stable until that transfer, or until reset.
module spike_column_arbiter #(
    parameter int NUM_COLS   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] col_valid,
    input  logic [NUM_COLS-1:0] col_on_off,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COL_W-1:0]    out_col,
    output logic                out_on_off,
    input  logic                clear_stats,
    output logic [CNT_W-1:0]    drop_count,
    output logic                overflow,
    output logic [NUM_COLS-1:0] fifo_full
);

    // FIFO address width. Each pointer has one extra wrap bit so that
    // full and empty can be told apart.
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    // Width large enough to hold the number of drops in one cycle.
    localparam int DW    = $clog2(NUM_COLS + 1);
    // Sum width for the saturating add. It holds the counter plus a full cycle of drops.
    localparam int SUM_W = CNT_W + DW;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            mem_q    [NUM_COLS][FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q [NUM_COLS];
    logic [PW-1:0]   wr_ptr_d [NUM_COLS];
    logic [PW-1:0]   rd_ptr_q [NUM_COLS];
    logic [PW-1:0]   rd_ptr_d [NUM_COLS];

    state_t          state_q, state_d;
    logic [COL_W-1:0] grant_q, grant_d;
`ifndef SPIKE_ARB_STRICT_PRIO_EN
    logic [COL_W-1:0] rr_q, rr_d;
`endif

    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Per-column status
    // ------------------------------------------------------------------
    logic [NUM_COLS-1:0] full;
    logic [NUM_COLS-1:0] pop;
    logic [NUM_COLS-1:0] push_ok;
    logic [NUM_COLS-1:0] drop;
    logic [NUM_COLS-1:0] nonempty_nx;
    logic                handshake;

    logic [COL_W-1:0]    arb_base;
    logic [COL_W-1:0]    arb_sel;
    logic                arb_found;

    logic [DW-1:0]       drop_num;
    logic [CNT_W-1:0]    cnt_base;
    logic [SUM_W-1:0]    cnt_sum;

    assign handshake = (state_q == ST_PRESENT) && out_ready;

`ifndef SPIKE_ARB_STRICT_PRIO_EN
    // Returns the column after c, wrapping from the last column to column 0.
    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] c);
        if (c == COL_W'(NUM_COLS - 1)) begin
            return '0;
        end
        return c + 1'b1;
    endfunction
`endif

    // Full flags, pop and push decisions. A full FIFO that is popped in the
    // same cycle still accepts the new event.
    always_comb begin
        full    = '0;
        pop     = '0;
        push_ok = '0;
        drop    = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            full[c]    = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                         (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
            pop[c]     = handshake && (grant_q == COL_W'(c));
            push_ok[c] = col_valid[c] && (!full[c] || pop[c]);
            drop[c]    = col_valid[c] && full[c] && !pop[c];
        end
    end

    // Next pointers and next occupancy. Arbitration sees the state after this
    // cycle's pushes and pop, so a new event is presented one cycle after enqueue.
    always_comb begin
        nonempty_nx = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            wr_ptr_d[c]    = wr_ptr_q[c] + PW'(push_ok[c]);
            rd_ptr_d[c]    = rd_ptr_q[c] + PW'(pop[c]);
            nonempty_nx[c] = (wr_ptr_d[c] != rd_ptr_d[c]);
        end
    end

    // Scan start point. After a pop, the scan starts at the column after the granted one.
    always_comb begin
`ifdef SPIKE_ARB_STRICT_PRIO_EN
        arb_base = '0;
`else
        arb_base = handshake ? next_col(grant_q) : rr_q;
`endif
    end

    // Pick the first non-empty column at or after arb_base, wrapping around.
    always_comb begin
        int               idx;
        logic [COL_W-1:0] idx_c;
        arb_found = 1'b0;
        arb_sel   = '0;
        idx       = 0;
        idx_c     = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            idx = int'(arb_base) + i;
            if (idx >= NUM_COLS) begin
                idx = idx - NUM_COLS;
            end
            idx_c = COL_W'(idx);
            if (!arb_found && nonempty_nx[idx_c]) begin
                arb_found = 1'b1;
                arb_sel   = idx_c;
            end
        end
    end

    // Presenter FSM next state. The grant is frozen while the router stalls.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifndef SPIKE_ARB_STRICT_PRIO_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d = ST_PRESENT;
                    grant_d = arb_sel;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
`ifndef SPIKE_ARB_STRICT_PRIO_EN
                    rr_d = next_col(grant_q);
`endif
                    if (arb_found) begin
                        grant_d = arb_sel;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Drop statistics. A drop in the same cycle as clear_stats takes precedence over the clear.
    always_comb begin
        drop_num = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            drop_num = drop_num + DW'(drop[c]);
        end
        cnt_base = clear_stats ? '0 : drop_count_q;
        cnt_sum  = SUM_W'(cnt_base) + SUM_W'(drop_num);
        if (cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
            drop_count_d = '1;
        end else begin
            drop_count_d = cnt_sum[CNT_W-1:0];
        end
        overflow_d = (clear_stats ? 1'b0 : overflow_q) | (|drop);
    end

    // Control registers. Reset empties every FIFO and aborts the presented spike.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
`ifndef SPIKE_ARB_STRICT_PRIO_EN
            rr_q         <= '0;
`endif
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            for (int c = 0; c < NUM_COLS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
`ifndef SPIKE_ARB_STRICT_PRIO_EN
            rr_q         <= rr_d;
`endif
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            for (int c = 0; c < NUM_COLS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
        end
    end

    // FIFO storage. This array is not reset. The reset pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_COLS; c++) begin
            if (push_ok[c]) begin
                mem_q[c][wr_ptr_q[c][AW-1:0]] <= col_on_off[c];
            end
        end
    end

    // Outputs. The presented on/off value is the head of the granted FIFO,
    // and it is forced to 0 while nothing is presented.
    assign out_valid  = (state_q == ST_PRESENT);
    assign out_col    = grant_q;
    assign out_on_off = out_valid && mem_q[grant_q][rd_ptr_q[grant_q][AW-1:0]];
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;
    assign fifo_full  = full;

endmodule

// File: doc/spike_column_arbiter.md
Name: spike_column_arbiter

Overview:
- Sits between the neuron-column spike outputs and the external spike router.
- Buffers per-column spike events (valid + on_off) in small per-column FIFOs, then issues them one per cycle to the router through a valid/ready handshake, with round-robin fairness.
- Removes the silent loss of simultaneous column spikes that a single-winner lookup would otherwise cause; counts and flags any events dropped on overflow.

Parameters:
- NUM_COLS, 4: number of neuron columns (requesters); >=1.
- FIFO_DEPTH, 4: entries per column FIFO; power of two, >=2.
- CNT_W, 16: width of the drop counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-high.
- col_valid  in  NUM_COLS  per-column spike strobe; one event per asserted bit per cycle.
- col_on_off  in  NUM_COLS  per-column on/off flag, sampled with col_valid.
- out_valid  out  1  spike available to router.
- out_ready  in  1  router accepts spike this cycle.
- out_col  out  $clog2(NUM_COLS) (min 1)  source column index of presented spike.
- out_on_off  out  1  on/off of presented spike.
- clear_stats  in  1  clears drop_count and overflow.
- drop_count  out  CNT_W  saturating count of dropped events.
- overflow  out  1  sticky; set on any drop.
- fifo_full  out  NUM_COLS  per-column FIFO full status (registered state).

Behaviour:
- Reset, sampled on a clk edge with reset=1:
  - all FIFOs empty; RR pointer = 0.
  - out_valid=0, out_col=0, out_on_off=0, drop_count=0, overflow=0, fifo_full=0.
  - reset overrides all other inputs; events presented during the reset cycle are discarded and not counted.
  - Reset mid-transfer aborts the presented spike; nothing is carried over.
- Enqueue: on an edge with col_valid[c]=1, col_on_off[c] is written to FIFO c if it is not full, or is popped in the same cycle.
- Full FIFO, no pop: the event is dropped.
  - drop_count increments by the number of columns dropped that cycle, saturating at 2^CNT_W-1.
  - overflow is set to 1.
- Latency: an event enqueued at edge n into an empty system is presented at out_valid in the cycle after edge n. Minimum latency is 1 cycle; there is no same-cycle bypass.
- Arbitration: two states.
  - IDLE (out_valid=0): every cycle, select the first non-empty FIFO scanning from the RR pointer upward, wrapping at NUM_COLS-1 -> 0. If found, register the grant and go to PRESENT.
  - PRESENT (out_valid=1): out_col and out_on_off show the head of the granted FIFO.
    - While out_ready=0: the grant, out_col and out_on_off hold stable. No re-arbitration, even if a higher-priority column fills.
    - On out_ready=1: the head is popped and the RR pointer becomes (granted col + 1) mod NUM_COLS.
    - Arbitration then runs again in the same cycle against the post-pop state. If any FIFO is non-empty, stay in PRESENT with the new grant, giving back-to-back throughput of 1 spike/cycle. Otherwise go to IDLE.
- Out_valid rule: out_valid never drops without a handshake, except on reset.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits each, wrap naturally. Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
- clear_stats:
  - Zeroes drop_count and overflow at the edge.
  - If a drop occurs in the same cycle, the result is drop_count = number of drops that cycle and overflow=1 (the new drop wins).
- Stat outputs: fifo_full, drop_count and overflow are registered outputs.

Optional Feature:
- Macro: SPIKE_ARB_STRICT_PRIO_EN.
- Defined: the RR pointer is removed. Arbitration always picks the lowest-index non-empty FIFO, so column 0 has highest priority. Hold-while-not-ready is unchanged.
- Undefined (default): round-robin as specified in Behaviour.

Test Plan:
- Single spike: after reset, col_valid=4'b0100, col_on_off=4'b0100 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_col=2, out_on_off=1 for exactly 1 cycle; drop_count=0.
- Simultaneous: col_valid=4'b1111 for 1 cycle, out_ready=1 -> out_col sequence 0,1,2,3 on 4 consecutive cycles, then out_valid=0. With SPIKE_ARB_STRICT_PRIO_EN defined, the order is the same.
- Fairness: col 0 and col 3 asserted every cycle, out_ready=1 -> grants alternate 0,3,0,3. With SPIKE_ARB_STRICT_PRIO_EN defined: col 0 is granted every cycle, col 3's FIFO fills after 4 events, then drop_count increments by 1/cycle and overflow=1.
- Backpressure: out_ready=0, col 1 pulsed 6 times with on_off=1,0,1,0,1,0 -> out_valid=1, out_col=1, out_on_off=1 held stable; fifo_full[1]=1; drop_count=2. Then out_ready=1 -> on_off 1,0,1,0 is delivered in order.
- Saturation/clear: CNT_W=4 overrides, force more than 15 drops -> drop_count=15. Assert clear_stats with no drop -> 0 and overflow=0. clear_stats together with 2 drops -> drop_count=2, overflow=1.
- Reset mid-operation: FIFOs holding 3 entries, out_valid=1 -> reset for 1 cycle gives out_valid=0 and all fifo_full=0 next cycle. No stale spike appears afterwards, and RR restarts at column 0.
